// File: rtl/audio_spi_pkg.sv
// audio_spi_pkg
// Shared constants for the audio SPI converters on the clk_135_w domain.
// The DAC transmit path (spi_dac_tx) uses the state enum, the frame bit
// positions and the frame-builder helper. The ADC receive path shares the
// same 16-bit framing and data width.
package audio_spi_pkg;

    // DAC transmit FSM states. Exposed on the debug port of spi_dac_tx.
    typedef enum logic [1:0] {
        DAC_IDLE    = 2'd0,
        DAC_SHIFT   = 2'd1,
        DAC_CS_HOLD = 2'd2,
        DAC_LDAC    = 2'd3
    } dac_state_e;

    // DAC command frame layout, MSB shifted first.
    localparam int DAC_FRAME_W    = 16;
    localparam int DAC_BIT_CHAN   = 15;
    localparam int DAC_BIT_BUF    = 14;
    localparam int DAC_BIT_GA_N   = 13;
    localparam int DAC_BIT_SHDN_N = 12;
    localparam int DAC_DATA_MSB   = 11;
    localparam int DAC_DATA_LSB   = 0;
    localparam int DAC_DATA_W     = 12;

    // Counter widths for the DAC transmitter.
    localparam int DAC_DIV_W     = 8;
    localparam int DAC_BIT_CNT_W = 4;

    // ADC receive path: same frame length and sample width as the DAC.
    localparam int ADC_FRAME_W  = 16;
    localparam int ADC_DATA_W   = 12;
    localparam int ADC_DATA_MSB = 11;

    // Build the 16-bit DAC command word from the control bits and a sample.
    function automatic logic [DAC_FRAME_W-1:0] dac_frame(
        input logic                  channel,
        input logic                  vref_buf,
        input logic                  ga_n,
        input logic                  shdn_n,
        input logic [DAC_DATA_W-1:0] data
    );
        logic [DAC_FRAME_W-1:0] f;
        f                            = '0;
        f[DAC_BIT_CHAN]              = channel;
        f[DAC_BIT_BUF]               = vref_buf;
        f[DAC_BIT_GA_N]              = ga_n;
        f[DAC_BIT_SHDN_N]            = shdn_n;
        f[DAC_DATA_MSB:DAC_DATA_LSB] = data;
        return f;
    endfunction

endpackage

// File: rtl/spi_clk_div.sv
// spi_clk_div
// Half-period tick generator for the DAC serial clock.
// Ports:
//   clk     - clock
//   reset_n - asynchronous active-low reset
//   clear   - synchronous restart of the count (asserted on state entry)
//   tick    - high on the last clk cycle of each DIV-cycle half period
module spi_clk_div
    import audio_spi_pkg::*;
#(
    parameter int unsigned DIV = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    output logic tick
);

    localparam logic [DAC_DIV_W-1:0] LAST = DAC_DIV_W'(DIV - 1);

    logic [DAC_DIV_W-1:0] count;

    // tick depends only on the count register, so the parent may derive
    // clear from its next-state logic without forming a combinational loop.
    assign tick = (count == LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clear || tick) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/spi_dac_tx.sv
// spi_dac_tx
// Serialises 12-bit audio samples into 16-bit DAC command frames (SPI mode 0,
// MSB first), then pulses the DAC latch strobe.
// Handshake: a sample transfers on the clk edge where sample_valid and
// sample_ready are both high; sample_ready is high only while idle, and a
// valid offered while busy is dropped (no queuing, no stall).
// Ports:
//   clk, reset_n         - clock, asynchronous active-low reset
//   sample, sample_valid - offered audio sample
//   sample_ready         - block is idle and will take a sample this edge
//   dac_cs_n, dac_sck,
//   dac_mosi, dac_ldac_n - registered SPI/latch outputs to the DAC
//   done                 - one-cycle pulse on the final latch-strobe cycle
//   state                - FSM state, for debug and checker binding
module spi_dac_tx
    import audio_spi_pkg::*;
#(
    parameter int unsigned CLK_DIV = 2,
    parameter logic        CHANNEL = 1'b0,
    parameter logic        BUF     = 1'b0,
    parameter logic        GA_N    = 1'b1,
    parameter logic        SHDN_N  = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [DAC_DATA_W-1:0] sample,
    input  logic                  sample_valid,
    output logic                  sample_ready,
    output logic                  dac_cs_n,
    output logic                  dac_sck,
    output logic                  dac_mosi,
    output logic                  dac_ldac_n,
    output logic                  done,
    output dac_state_e            state
);

    dac_state_e                 state_q, state_d;
    logic [DAC_FRAME_W-1:0]     frame_q, frame_d;
    logic [DAC_BIT_CNT_W-1:0]   bit_q, bit_d;
    logic                       cs_n_d, sck_d, mosi_d, ldac_n_d;
    logic                       tick;
    logic                       div_clear;
    logic                       transfer;

    assign sample_ready = (state_q == DAC_IDLE);
    assign transfer     = sample_valid && sample_ready;
    assign done         = (state_q == DAC_LDAC) && tick;
    assign state        = state_q;

    // Restart the half-period count on every state change and hold it at
    // zero while idle, so each state starts with a full CLK_DIV interval.
    assign div_clear = (state_d != state_q) || (state_q == DAC_IDLE);

    spi_clk_div #(
        .DIV (CLK_DIV)
    ) u_clk_div (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (div_clear),
        .tick    (tick)
    );

    always_comb begin
        state_d  = state_q;
        frame_d  = frame_q;
        bit_d    = bit_q;
        cs_n_d   = dac_cs_n;
        sck_d    = dac_sck;
        mosi_d   = dac_mosi;
        ldac_n_d = dac_ldac_n;

        case (state_q)
            DAC_IDLE: begin
                cs_n_d   = 1'b1;
                sck_d    = 1'b0;
                mosi_d   = 1'b0;
                ldac_n_d = 1'b1;
                if (transfer) begin
                    frame_d = dac_frame(CHANNEL, BUF, GA_N, SHDN_N, sample);
                    bit_d   = DAC_BIT_CNT_W'(DAC_FRAME_W - 1);
                    state_d = DAC_SHIFT;
                    cs_n_d  = 1'b0;
                    mosi_d  = frame_d[DAC_FRAME_W-1];
                end
            end

            DAC_SHIFT: begin
                if (tick) begin
                    if (!dac_sck) begin
                        // End of low phase: rising edge, data already stable.
                        sck_d = 1'b1;
                    end else begin
                        // End of high phase: falling edge and next bit.
                        // bit_q wraps 0 -> 15 here only, on exit from SHIFT.
                        sck_d = 1'b0;
                        bit_d = bit_q - 1'b1;
                        if (bit_q == '0) begin
                            state_d = DAC_CS_HOLD;
                            mosi_d  = 1'b0;
                        end else begin
                            mosi_d = frame_q[bit_d];
                        end
                    end
                end
            end

            DAC_CS_HOLD: begin
                sck_d  = 1'b0;
                mosi_d = 1'b0;
                if (tick) begin
                    state_d  = DAC_LDAC;
                    cs_n_d   = 1'b1;
                    ldac_n_d = 1'b0;
                end
            end

            DAC_LDAC: begin
                if (tick) begin
                    state_d  = DAC_IDLE;
                    ldac_n_d = 1'b1;
                end
            end

            default: begin
                state_d = DAC_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= DAC_IDLE;
            frame_q    <= '0;
            bit_q      <= '0;
            dac_cs_n   <= 1'b1;
            dac_sck    <= 1'b0;
            dac_mosi   <= 1'b0;
            dac_ldac_n <= 1'b1;
        end else begin
            state_q    <= state_d;
            frame_q    <= frame_d;
            bit_q      <= bit_d;
            dac_cs_n   <= cs_n_d;
            dac_sck    <= sck_d;
            dac_mosi   <= mosi_d;
            dac_ldac_n <= ldac_n_d;
        end
    end

endmodule

// File: tb/tb_spi_dac_tx.sv
// tb_spi_dac_tx
// Two instances: dut_a (CLK_DIV=2, default control bits, frame header 0x3)
// and dut_b (CLK_DIV=1, SHDN_N=0, frame header 0x2). A negedge monitor
// decodes the SPI lines into frames and timing figures; the tests compare
// those against frames and durations computed from the frame format.
module tb_spi_dac_tx;
    import audio_spi_pkg::*;

    localparam int unsigned A_DIV = 2;
    localparam int unsigned B_DIV = 1;
    localparam logic        B_SHDN_N = 1'b0;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- DUT connections ----------------
    logic [11:0] sample_v [2];
    logic [1:0]  valid_v;
    logic [1:0]  ready_v, cs_n_v, sck_v, mosi_v, ldac_v, done_v;
    dac_state_e  st_a, st_b;

    spi_dac_tx #(.CLK_DIV(A_DIV)) dut_a (
        .clk(clk), .reset_n(reset_n), .sample(sample_v[0]), .sample_valid(valid_v[0]),
        .sample_ready(ready_v[0]), .dac_cs_n(cs_n_v[0]), .dac_sck(sck_v[0]),
        .dac_mosi(mosi_v[0]), .dac_ldac_n(ldac_v[0]), .done(done_v[0]), .state(st_a)
    );

    spi_dac_tx #(.CLK_DIV(B_DIV), .SHDN_N(B_SHDN_N)) dut_b (
        .clk(clk), .reset_n(reset_n), .sample(sample_v[1]), .sample_valid(valid_v[1]),
        .sample_ready(ready_v[1]), .dac_cs_n(cs_n_v[1]), .dac_sck(sck_v[1]),
        .dac_mosi(mosi_v[1]), .dac_ldac_n(ldac_v[1]), .done(done_v[1]), .state(st_b)
    );

    // ---------------- scoreboard ----------------
    logic [15:0] exp_q[$];
    logic [15:0] rx_q[$];
    int n_checks = 0;
    int n_fail   = 0;

    // ---------------- monitor ----------------
    logic [15:0] rx [2];
    int bits [2], run_cs [2], run_ldac [2];
    int last_bits [2], last_cs_len [2], last_ldac_len [2];
    int frames_seen [2], ldac_cnt [2], done_cnt [2];
    int done_cyc [2], accept_cyc [2], ready_rise [2];
    int fall_prev [2], fall_last [2];
    int last_rise [2], rmin [2], rmax [2], last_rmin [2], last_rmax [2];
    int mosi_viol [2], idle_viol [2];
    logic p_cs [2], p_sck [2], p_mosi [2], p_ldac [2], p_ready [2];
    int iv;

    initial begin
        for (int d = 0; d < 2; d++) begin
            rx[d] = '0; bits[d] = 0; run_cs[d] = 0; run_ldac[d] = 0;
            last_bits[d] = 0; last_cs_len[d] = 0; last_ldac_len[d] = 0;
            frames_seen[d] = 0; ldac_cnt[d] = 0; done_cnt[d] = 0;
            done_cyc[d] = 0; accept_cyc[d] = 0; ready_rise[d] = 0;
            fall_prev[d] = 0; fall_last[d] = 0; last_rise[d] = 0;
            rmin[d] = 0; rmax[d] = 0; last_rmin[d] = 0; last_rmax[d] = 0;
            mosi_viol[d] = 0; idle_viol[d] = 0;
            p_cs[d] = 1'b1; p_sck[d] = 1'b0; p_mosi[d] = 1'b0; p_ldac[d] = 1'b1; p_ready[d] = 1'b1;
        end
    end

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (!reset_n) begin
                // An aborted frame is discarded, not logged.
                rx[d] = '0; bits[d] = 0; run_cs[d] = 0; run_ldac[d] = 0;
                p_cs[d] = 1'b1; p_sck[d] = 1'b0; p_mosi[d] = 1'b0; p_ldac[d] = 1'b1; p_ready[d] = 1'b1;
            end else begin
                if (ready_v[d] && (cs_n_v[d] !== 1'b1 || sck_v[d] !== 1'b0 || mosi_v[d] !== 1'b0 ||
                                   ldac_v[d] !== 1'b1 || done_v[d] !== 1'b0))
                    idle_viol[d]++;
                if (ready_v[d] && !p_ready[d]) ready_rise[d] = cyc;
                if (valid_v[d] && ready_v[d]) accept_cyc[d] = cyc;
                if (done_v[d]) begin done_cnt[d]++; done_cyc[d] = cyc; end

                if (cs_n_v[d] === 1'b0) begin
                    if (p_cs[d]) begin
                        fall_prev[d] = fall_last[d]; fall_last[d] = cyc;
                        run_cs[d] = 0; bits[d] = 0; rx[d] = '0; rmin[d] = 1 << 20; rmax[d] = 0;
                    end
                    run_cs[d]++;
                    if (sck_v[d] && !p_sck[d]) begin
                        if (bits[d] > 0) begin
                            iv = cyc - last_rise[d];
                            if (iv < rmin[d]) rmin[d] = iv;
                            if (iv > rmax[d]) rmax[d] = iv;
                        end
                        last_rise[d] = cyc;
                        rx[d] = {rx[d][14:0], mosi_v[d]};
                        bits[d]++;
                    end
                    if (sck_v[d] && p_sck[d] && mosi_v[d] !== p_mosi[d]) mosi_viol[d]++;
                end else if (!p_cs[d]) begin
                    rx_q.push_back(rx[d]);
                    last_bits[d] = bits[d]; last_cs_len[d] = run_cs[d];
                    last_rmin[d] = rmin[d]; last_rmax[d] = rmax[d];
                    frames_seen[d]++;
                end

                if (!ldac_v[d]) begin
                    if (p_ldac[d]) run_ldac[d] = 0;
                    run_ldac[d]++;
                end else if (!p_ldac[d]) begin
                    last_ldac_len[d] = run_ldac[d];
                    ldac_cnt[d]++;
                end

                p_cs[d] = cs_n_v[d]; p_sck[d] = sck_v[d]; p_mosi[d] = mosi_v[d];
                p_ldac[d] = ldac_v[d]; p_ready[d] = ready_v[d];
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic drive_sample(input int d, input logic [11:0] s);
        int t = 0;
        @(posedge clk); #1;
        while (!ready_v[d] && t < 300) begin @(posedge clk); #1; t++; end
        if (!ready_v[d]) begin
            n_checks++; n_fail++;
            $display("FAIL drive_timeout dut%0d: ready=%0b required 1", d, ready_v[d]);
        end
        sample_v[d] = s;
        valid_v[d]  = 1'b1;
        @(posedge clk); #1;
        valid_v[d]  = 1'b0;
    endtask

    task automatic wait_frame(input int d, input int f0);
        int t = 0;
        @(negedge clk); #1;
        while (!(frames_seen[d] > f0 && ready_v[d]) && t < 400) begin @(negedge clk); #1; t++; end
        if (!(frames_seen[d] > f0 && ready_v[d])) begin
            n_checks++; n_fail++;
            $display("FAIL frame_timeout dut%0d: frames=%0d required >%0d", d, frames_seen[d], f0);
        end
    endtask

    function automatic logic [15:0] hdr_of(input int d);
        logic shdn;
        shdn = (d == 0) ? 1'b1 : B_SHDN_N;
        // channel 0, buffer off, 1x gain on both instances
        return 16'((0 << 15) + (0 << 14) + (1 << 13) + (int'(shdn) << 12));
    endfunction

    // ---------------- tests ----------------
    task automatic test_reset();
        repeat (3) @(negedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            n_checks++; if (ready_v[d] !== 1'b1) begin n_fail++; $display("FAIL reset_ready dut%0d: got %0b want 1", d, ready_v[d]); end
            n_checks++; if (cs_n_v[d] !== 1'b1) begin n_fail++; $display("FAIL reset_cs_n dut%0d: got %0b want 1", d, cs_n_v[d]); end
            n_checks++; if (sck_v[d] !== 1'b0) begin n_fail++; $display("FAIL reset_sck dut%0d: got %0b want 0", d, sck_v[d]); end
            n_checks++; if (mosi_v[d] !== 1'b0) begin n_fail++; $display("FAIL reset_mosi dut%0d: got %0b want 0", d, mosi_v[d]); end
            n_checks++; if (ldac_v[d] !== 1'b1) begin n_fail++; $display("FAIL reset_ldac_n dut%0d: got %0b want 1", d, ldac_v[d]); end
            n_checks++; if (done_v[d] !== 1'b0) begin n_fail++; $display("FAIL reset_done dut%0d: got %0b want 0", d, done_v[d]); end
        end
        n_checks++; if (st_a !== DAC_IDLE) begin n_fail++; $display("FAIL reset_state: got %0d want %0d", st_a, DAC_IDLE); end
    endtask

    task automatic test_first_accept();
        logic [11:0] s;
        logic [15:0] got, want;
        int f0;
        s = 12'($urandom_range(0, 4095));
        f0 = frames_seen[0];
        @(negedge clk);
        reset_n = 1'b1;
        sample_v[0] = s;
        valid_v[0] = 1'b1;
        exp_q.push_back(hdr_of(0) | {4'h0, s});
        @(posedge clk); #1;
        valid_v[0] = 1'b0;
        n_checks++; if (cs_n_v[0] !== 1'b0) begin n_fail++; $display("FAIL first_accept_cs_n: got %0b want 0", cs_n_v[0]); end
        n_checks++; if (ready_v[0] !== 1'b0) begin n_fail++; $display("FAIL first_accept_ready: got %0b want 0", ready_v[0]); end
        wait_frame(0, f0);
        got = (rx_q.size() > 0) ? rx_q.pop_front() : 16'hDEAD;
        want = exp_q.pop_front();
        n_checks++; if (got !== want) begin n_fail++; $display("FAIL first_accept_frame: got %04h want %04h", got, want); end
    endtask

    task automatic test_frames(input int d, input logic [11:0] first, input int n);
        logic [11:0] s;
        logic [15:0] got, want;
        int f0, dn0, l0, div;
        div = (d == 0) ? int'(A_DIV) : int'(B_DIV);
        for (int i = 0; i < n; i++) begin
            s = (i == 0) ? first : 12'($urandom_range(0, 4095));
            exp_q.push_back(hdr_of(d) | {4'h0, s});
            f0 = frames_seen[d]; dn0 = done_cnt[d]; l0 = ldac_cnt[d];
            drive_sample(d, s);
            wait_frame(d, f0);
            got = (rx_q.size() > 0) ? rx_q.pop_front() : 16'hDEAD;
            want = exp_q.pop_front();
            n_checks++; if (got !== want) begin n_fail++; $display("FAIL frame dut%0d: got %04h want %04h", d, got, want); end
            n_checks++; if (last_bits[d] !== 16) begin n_fail++; $display("FAIL sck_edges dut%0d: got %0d want 16", d, last_bits[d]); end
            n_checks++; if (last_cs_len[d] !== 33 * div) begin n_fail++; $display("FAIL cs_low_len dut%0d: got %0d want %0d", d, last_cs_len[d], 33 * div); end
            n_checks++; if (last_ldac_len[d] !== div) begin n_fail++; $display("FAIL ldac_low_len dut%0d: got %0d want %0d", d, last_ldac_len[d], div); end
            n_checks++; if (ldac_cnt[d] !== l0 + 1) begin n_fail++; $display("FAIL ldac_pulses dut%0d: got %0d want %0d", d, ldac_cnt[d], l0 + 1); end
            n_checks++; if (done_cnt[d] !== dn0 + 1) begin n_fail++; $display("FAIL done_pulses dut%0d: got %0d want %0d", d, done_cnt[d], dn0 + 1); end
            n_checks++; if (ready_rise[d] - done_cyc[d] !== 1) begin n_fail++; $display("FAIL done_to_ready dut%0d: got %0d want 1", d, ready_rise[d] - done_cyc[d]); end
            n_checks++; if (ready_rise[d] - accept_cyc[d] !== 34 * div + 1) begin n_fail++; $display("FAIL accept_to_ready dut%0d: got %0d want %0d", d, ready_rise[d] - accept_cyc[d], 34 * div + 1); end
            n_checks++; if (last_rmin[d] !== 2 * div || last_rmax[d] !== 2 * div) begin n_fail++; $display("FAIL sck_period dut%0d: got %0d..%0d want %0d", d, last_rmin[d], last_rmax[d], 2 * div); end
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] got, want;
        int f0, t;
        f0 = frames_seen[0];
        exp_q.push_back(hdr_of(0) | 16'h000);
        exp_q.push_back(hdr_of(0) | 16'hFFF);
        @(posedge clk); #1;
        sample_v[0] = 12'h000;
        valid_v[0] = 1'b1;
        @(posedge clk); #1;
        sample_v[0] = 12'hFFF;
        t = 0;
        while (!ready_v[0] && t < 300) begin @(posedge clk); #1; t++; end
        @(posedge clk); #1;
        valid_v[0] = 1'b0;
        wait_frame(0, f0 + 1);
        n_checks++; if (frames_seen[0] !== f0 + 2) begin n_fail++; $display("FAIL b2b_frame_count: got %0d want %0d", frames_seen[0], f0 + 2); end
        for (int i = 0; i < 2; i++) begin
            got = (rx_q.size() > 0) ? rx_q.pop_front() : 16'hDEAD;
            want = exp_q.pop_front();
            n_checks++; if (got !== want) begin n_fail++; $display("FAIL b2b_frame%0d: got %04h want %04h", i, got, want); end
        end
        n_checks++; if (fall_last[0] - fall_prev[0] !== 34 * int'(A_DIV) + 1) begin n_fail++; $display("FAIL b2b_cs_spacing: got %0d want %0d", fall_last[0] - fall_prev[0], 34 * int'(A_DIV) + 1); end
    endtask

    task automatic test_busy_ignored();
        logic [11:0] s;
        logic [15:0] got, want;
        int f0, dn0;
        s = 12'($urandom_range(0, 4095));
        exp_q.push_back(hdr_of(0) | {4'h0, s});
        f0 = frames_seen[0]; dn0 = done_cnt[0];
        drive_sample(0, s);
        repeat (20) @(posedge clk);
        #1;
        sample_v[0] = 12'h555;
        valid_v[0] = 1'b1;
        @(posedge clk); #1;
        valid_v[0] = 1'b0;
        wait_frame(0, f0);
        repeat (100) @(negedge clk);
        #1;
        got = (rx_q.size() > 0) ? rx_q.pop_front() : 16'hDEAD;
        want = exp_q.pop_front();
        n_checks++; if (got !== want) begin n_fail++; $display("FAIL busy_frame: got %04h want %04h", got, want); end
        n_checks++; if (frames_seen[0] !== f0 + 1) begin n_fail++; $display("FAIL busy_extra_frame: got %0d want %0d", frames_seen[0], f0 + 1); end
        n_checks++; if (done_cnt[0] !== dn0 + 1) begin n_fail++; $display("FAIL busy_done_count: got %0d want %0d", done_cnt[0], dn0 + 1); end
        n_checks++; if (ready_v[0] !== 1'b1) begin n_fail++; $display("FAIL busy_ready_after: got %0b want 1", ready_v[0]); end
    endtask

    task automatic test_reset_mid_frame();
        int f0, dn0, l0, t;
        f0 = frames_seen[0]; dn0 = done_cnt[0]; l0 = ldac_cnt[0];
        drive_sample(0, 12'($urandom_range(0, 4095)));
        t = 0;
        @(negedge clk); #1;
        while (bits[0] < 8 && t < 300) begin @(negedge clk); #1; t++; end
        n_checks++; if (bits[0] !== 8) begin n_fail++; $display("FAIL rst_reach_bit7: got %0d edges want 8", bits[0]); end
        repeat (3) @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        n_checks++; if (cs_n_v[0] !== 1'b1) begin n_fail++; $display("FAIL rst_mid_cs_n: got %0b want 1", cs_n_v[0]); end
        n_checks++; if (sck_v[0] !== 1'b0) begin n_fail++; $display("FAIL rst_mid_sck: got %0b want 0", sck_v[0]); end
        n_checks++; if (ldac_v[0] !== 1'b1) begin n_fail++; $display("FAIL rst_mid_ldac_n: got %0b want 1", ldac_v[0]); end
        n_checks++; if (ready_v[0] !== 1'b1) begin n_fail++; $display("FAIL rst_mid_ready: got %0b want 1", ready_v[0]); end
        n_checks++; if (st_a !== DAC_IDLE) begin n_fail++; $display("FAIL rst_mid_state: got %0d want %0d", st_a, DAC_IDLE); end
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (100) @(negedge clk);
        #1;
        n_checks++; if (done_cnt[0] !== dn0) begin n_fail++; $display("FAIL rst_mid_done: got %0d want %0d", done_cnt[0], dn0); end
        n_checks++; if (ldac_cnt[0] !== l0) begin n_fail++; $display("FAIL rst_mid_ldac_pulse: got %0d want %0d", ldac_cnt[0], l0); end
        n_checks++; if (frames_seen[0] !== f0 || rx_q.size() !== 0) begin n_fail++; $display("FAIL rst_mid_frame_logged: got %0d want %0d", frames_seen[0], f0); end
    endtask

    task automatic test_line_rules();
        for (int d = 0; d < 2; d++) begin
            n_checks++; if (mosi_viol[d] !== 0) begin n_fail++; $display("FAIL mosi_stable_high_sck dut%0d: got %0d changes want 0", d, mosi_viol[d]); end
            n_checks++; if (idle_viol[d] !== 0) begin n_fail++; $display("FAIL idle_outputs dut%0d: got %0d bad cycles want 0", d, idle_viol[d]); end
        end
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- main sequence ----------------
    initial begin
        valid_v = '0;
        sample_v[0] = '0;
        sample_v[1] = '0;
        test_reset();
        test_first_accept();
        test_frames(0, 12'hABC, 6);
        test_busy_ignored();
        test_back_to_back();
        test_reset_mid_frame();
        test_frames(0, 12'($urandom_range(0, 4095)), 2);
        test_frames(1, 12'h800, 6);
        test_line_rules();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_dac_tx.md
SPI_DAC_TX -- requirements
Module: spi_dac_tx

Interface
REQ-001 The block SHALL have parameter CLK_DIV, default 2: SCK half-period in clk cycles; legal range 1..255.
REQ-002 The block SHALL have parameter CHANNEL, default 0: DAC channel select, frame bit 15.
REQ-003 The block SHALL have parameter BUF, default 0: Vref buffer enable, frame bit 14.
REQ-004 The block SHALL have parameter GA_N, default 1: gain select (1 = 1x), frame bit 13.
REQ-005 The block SHALL have parameter SHDN_N, default 1: output active (0 = DAC shutdown), frame bit 12.
REQ-006 The block SHALL have port clk  in  1: sole clock (clk_135_w domain).
REQ-007 The block SHALL have port reset_n  in  1: reset, asynchronous and active-low.
REQ-008 The block SHALL have port sample  in  12: unsigned audio sample.
REQ-009 The block SHALL have port sample_valid  in  1: sample offered.
REQ-010 The block SHALL have port sample_ready  out  1: block can accept a sample.
REQ-011 The block SHALL have ports dac_cs_n / dac_sck / dac_mosi / dac_ldac_n  out  1 each: SPI chip select, serial clock (mode 0), serial data, latch strobe.
REQ-012 The block SHALL have port done  out  1: one-cycle pulse when the DAC latch completes.

Function
REQ-013 Transfer SHALL occur on the clk edge where sample_valid && sample_ready; the frame latched is {CHANNEL, BUF, GA_N, SHDN_N, sample}, 16 bits.
REQ-014 States SHALL be IDLE, SHIFT, CS_HOLD and LDAC; IDLE->SHIFT on transfer, SHIFT->CS_HOLD after bit 0 high phase, CS_HOLD->LDAC after CLK_DIV cycles, LDAC->IDLE after CLK_DIV cycles.
REQ-015 sample_ready SHALL be 1 only in IDLE; valid while busy is ignored, with no queuing and no stall of the current frame.
REQ-016 In SHIFT, each bit n (15 down to 0) SHALL be CLK_DIV cycles with sck=0 then CLK_DIV cycles with sck=1; dac_mosi=frame[n] throughout; MSB first.
REQ-017 dac_cs_n SHALL be 0 from the first SHIFT cycle (the cycle after transfer) through the last CS_HOLD cycle, i.e. for 32*CLK_DIV + CLK_DIV cycles.
REQ-018 In CS_HOLD, sck SHALL be 0 and mosi SHALL be 0.
REQ-019 In LDAC, dac_cs_n=1 and dac_ldac_n=0 for CLK_DIV cycles.
REQ-020 done SHALL pulse high for the single cycle of the LDAC->IDLE transition; sample_ready SHALL be 1 the following cycle.
REQ-021 Back-to-back throughput SHALL be one frame per 34*CLK_DIV + 1 cycles, where the +1 is the IDLE accept cycle.
REQ-022 The divider counter SHALL be 8 bits and the bit counter 4 bits; the bit counter wraps 0->15 only on exit to CS_HOLD, and no other wrap is permitted.
REQ-023 All SPI outputs SHALL be registered, with no combinational path from sample/sample_valid.
REQ-024 In IDLE, outputs SHALL be cs_n=1, sck=0, mosi=0, ldac_n=1, done=0.

Reset
REQ-025 On reset_n low, all state SHALL asynchronously return to IDLE: sample_ready=1, dac_cs_n=1, dac_sck=0, dac_mosi=0, dac_ldac_n=1, done=0, counters 0.
REQ-026 Reset mid-frame SHALL abort the frame with no LDAC pulse; the DAC retains its previous value.
REQ-027 The first transfer SHALL be accepted on the first clk edge after reset_n deasserts.

Structure
REQ-028 The state enum and frame bit positions (15/14/13/12, data 11:0) SHALL reside in shared package audio_spi_pkg, alongside the ADC SPI constants.
REQ-029 One sub-module, spi_clk_div, SHALL generate the CLK_DIV half-period tick; it is reset to 0 at each state entry.
REQ-030 The parent SHALL drive the block from the LPF output on clk_135_w, pairing it with the existing ADC SPI receive path.

Verification
REQ-031 Scenario: CLK_DIV=2, defaults, sample=0xABC pulsed valid -> rising-sck bits 0011 1010 1011 1100 (0x3ABC); cs_n low 66 cycles; ldac_n low 2 cycles; done 1 cycle.
REQ-032 Scenario: valid held high continuously, samples 0x000 then 0xFFF -> frames 0x3000 and 0x3FFF; second cs_n fall exactly 69 cycles after the first.
REQ-033 Scenario: valid pulsed during SHIFT with sample=0x555 -> ignored; frame in flight unchanged; no extra frame.
REQ-034 Scenario: reset_n low at bit 7 -> same cycle cs_n=1, sck=0, ldac_n=1; no done pulse; sample_ready=1.
REQ-035 Scenario: CLK_DIV=1, SHDN_N=0, sample=0x800 -> frame 0x2800; sck period 2 cycles; total 35 cycles from accept to ready.
REQ-036 Scenario: across all scenarios -> assertion that dac_mosi never changes while dac_sck=1 and cs_n=0.
